framebuf_reader: RTL and testbench



---
 rtl/fbr_pkg.sv | 25 ++
 rtl/fbr_delay_line.sv | 29 ++
 rtl/framebuf_reader.sv | 148 ++++++++++++++
 tb/tb_framebuf_reader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fbr_pkg.sv
// Shared types and constants for the frame-buffer read path (framebuf_reader).
package fbr_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  localparam int SCR_W = 640;
  localparam int SCR_H = 480;

  // Bar order left to right: white, yellow, cyan, green, magenta, red, blue, black.
  localparam rgb444_t BAR_COLOURS [8] = '{
    '{4'hF, 4'hF, 4'hF},
    '{4'hF, 4'hF, 4'h0},
    '{4'h0, 4'hF, 4'hF},
    '{4'h0, 4'hF, 4'h0},
    '{4'hF, 4'h0, 4'hF},
    '{4'hF, 4'h0, 4'h0},
    '{4'h0, 4'h0, 4'hF},
    '{4'h0, 4'h0, 4'h0}
  };

endpackage

// File: rtl/fbr_delay_line.sv
// Fixed-depth shift register with an asynchronous reset value; aligns side-band
// signals with the frame-buffer read pipeline.
module fbr_delay_line
  import fbr_pkg::*;
#(
  parameter int          W       = 1,
  parameter int          D       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_sr [D];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) r_sr[i] <= RST_VAL;
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < D; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_q = r_sr[D-1];

endmodule

// File: rtl/framebuf_reader.sv
// 640x480 -> 320x240 frame-buffer reader with 2x pixel/line doubling and sync re-timing.
// Optional colour-bar generator enabled by defining FBR_TEST_PATTERN_EN (adds tp_sel).
module framebuf_reader
  import fbr_pkg::*;
#(
  parameter int   SRC_W     = 320,
  parameter int   SRC_H     = 240,
  parameter int   ADDR_W    = 17,
  parameter int   PIX_W     = 12,
  parameter int   RAM_LAT   = 1,
  parameter logic VS_ACTIVE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              de_in,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              hs_out,
  output logic              vs_out,
  output logic              de_out,
`ifdef FBR_TEST_PATTERN_EN
  input  logic              tp_sel,
`endif
  output logic              frame_start
);

  localparam int                L        = RAM_LAT + 2;
  localparam int                ROW_W    = $clog2(SRC_H + 1);
  localparam logic [9:0]        SRC_W_C  = 10'(SRC_W);
  localparam logic [ROW_W-1:0]  SRC_H_C  = ROW_W'(SRC_H);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SRC_W);

  logic              r_vs_prev, r_de_prev, r_line_phase, r_frame_ok, r_frame_start;
  logic [ROW_W-1:0]  r_row_idx;
  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] r_rd_addr_a;
  logic              r_in_src_a;
  rgb444_t           r_pix_b;

  logic              w_vs_edge, w_de_fall, w_row_ok, w_in_src, w_in_src_b;
  logic [8:0]        w_col;
  logic [ADDR_W-1:0] w_addr;
  logic [2:0]        w_sync_d;
  rgb444_t           w_pix;
  logic              w_unused;

  // Row position is derived from line count, so draw_y only serves as a debug aid upstream.
  assign w_unused  = ^{draw_y, draw_x[0]};

  assign w_col     = draw_x[9:1];
  assign w_vs_edge = (vs_in == VS_ACTIVE) && (r_vs_prev != VS_ACTIVE);
  assign w_de_fall = r_de_prev & ~de_in;
  assign w_row_ok  = r_row_idx < SRC_H_C;
  assign w_in_src  = r_frame_ok & de_in & ({1'b0, w_col} < SRC_W_C) & w_row_ok;
  assign w_addr    = r_row_base + ADDR_W'(w_col);

  // Frame reset has priority over the end-of-line row advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_prev     <= ~VS_ACTIVE;
      r_de_prev     <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_ok    <= 1'b0;
      r_line_phase  <= 1'b0;
      r_row_idx     <= '0;
      r_row_base    <= '0;
    end else begin
      r_vs_prev     <= vs_in;
      r_de_prev     <= de_in;
      r_frame_start <= w_vs_edge;
      if (w_vs_edge) begin
        r_frame_ok   <= 1'b1;
        r_line_phase <= 1'b0;
        r_row_idx    <= '0;
        r_row_base   <= '0;
      end else if (w_de_fall) begin
        r_line_phase <= ~r_line_phase;
        if (r_line_phase && w_row_ok) begin
          r_row_base <= r_row_base + ROW_STEP;
          r_row_idx  <= r_row_idx + ROW_W'(1);
        end
      end
    end
  end

  // Stage A: address issue; out-of-source cycles keep the last valid address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_addr_a <= '0;
      r_in_src_a  <= 1'b0;
    end else begin
      r_in_src_a <= w_in_src;
      if (w_in_src) r_rd_addr_a <= w_addr;
    end
  end

  fbr_delay_line #(.W(1), .D(RAM_LAT), .RST_VAL(1'b0)) u_src_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (r_in_src_a),
    .o_q   (w_in_src_b)
  );

  fbr_delay_line #(.W(3), .D(L), .RST_VAL({~VS_ACTIVE, ~VS_ACTIVE, 1'b0})) u_sync_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   ({hs_in, vs_in, de_in}),
    .o_q   (w_sync_d)
  );

`ifdef FBR_TEST_PATTERN_EN
  logic [3:0] w_tp_b;

  fbr_delay_line #(.W(4), .D(L - 1), .RST_VAL(4'd0)) u_tp_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   ({tp_sel, draw_x[9:7]}),
    .o_q   (w_tp_b)
  );

  assign w_pix = w_tp_b[3] ? BAR_COLOURS[w_tp_b[2:0]] : rgb444_t'(rd_data);
`else
  assign w_pix = rgb444_t'(rd_data);
`endif

  // Stage B: colour register, blanked outside the active source area.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pix_b <= '0;
    else        r_pix_b <= w_in_src_b ? w_pix : '0;
  end

  assign rd_addr     = r_rd_addr_a;
  assign red         = r_pix_b.r;
  assign green       = r_pix_b.g;
  assign blue        = r_pix_b.b;
  assign hs_out      = w_sync_d[2];
  assign vs_out      = w_sync_d[1];
  assign de_out      = w_sync_d[0];
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_framebuf_reader.sv
// Scoreboard bench for framebuf_reader: RAM_LAT=1 and RAM_LAT=3 instances driven in parallel.
module tb_framebuf_reader;
  import fbr_pkg::*;

  typedef struct { int due; int v; } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hs_in = 1'b1, vs_in = 1'b1, de_in = 1'b0, tp_sel = 1'b0, force_fff = 1'b0;
  logic [9:0]  draw_x = '0, draw_y = '0;
  logic [16:0] rd_addr1, rd_addr3;
  logic [11:0] rd_data1, rd_data3;
  logic [3:0]  red1, green1, blue1, red3, green3, blue3;
  logic        hs_out1, vs_out1, de_out1, fs_out1, hs_out3, vs_out3, de_out3, fs_out3;
  logic [11:0] ram1_q [1];
  logic [11:0] ram3_q [3];
  logic [2:0]  hist [8];

  int   cyc = 0, rst_cyc = 0, checks = 0, errors = 0, fs1 = 0, fs3 = 0, fs_base1, fs_base3;
  int   m_last = 0;
  bit   m_ok = 0, m_vs_prev = 1;
  exp_t qa[$], qc1[$], qc3[$];
  int   XS[6] = '{0, 1, 2, 4, 700, 638};

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  framebuf_reader #(.RAM_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
    .draw_x(draw_x), .draw_y(draw_y), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .red(red1), .green(green1), .blue(blue1), .hs_out(hs_out1), .vs_out(vs_out1),
`ifdef FBR_TEST_PATTERN_EN
    .tp_sel(tp_sel),
`endif
    .de_out(de_out1), .frame_start(fs_out1)
  );

  framebuf_reader #(.RAM_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
    .draw_x(draw_x), .draw_y(draw_y), .rd_addr(rd_addr3), .rd_data(rd_data3),
    .red(red3), .green(green3), .blue(blue3), .hs_out(hs_out3), .vs_out(vs_out3),
`ifdef FBR_TEST_PATTERN_EN
    .tp_sel(tp_sel),
`endif
    .de_out(de_out3), .frame_start(fs_out3)
  );

  // BRAM models return the low 12 address bits after RAM_LAT clocks.
  always @(posedge clk) begin
    ram1_q[0] <= rd_addr1[11:0];
    ram3_q[0] <= rd_addr3[11:0];
    ram3_q[1] <= ram3_q[0];
    ram3_q[2] <= ram3_q[1];
  end
  assign rd_data1 = force_fff ? 12'hFFF : ram1_q[0];
  assign rd_data3 = force_fff ? 12'hFFF : ram3_q[2];

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic miss(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=no-entry required=entry t=%0t", nm, $time);
  endtask

  function automatic int bar(input int x);
    case (x >> 7)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  // Monitor: pops expectations as the DUTs present data.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (qa.size() > 0 && qa[0].due == cyc) begin
        e = qa.pop_front();
        chk("rd_addr_lat1", rd_addr1, e.v);
        chk("rd_addr_lat3", rd_addr3, e.v);
      end
      if (de_out1) begin
        if (qc1.size() == 0) miss("colour_lat1");
        else begin
          e = qc1.pop_front();
          chk("colour_lat1", {red1, green1, blue1}, e.v);
          chk("colour_cycle_lat1", cyc, e.due);
        end
      end else chk("blank_lat1", {red1, green1, blue1}, 0);
      if (de_out3) begin
        if (qc3.size() == 0) miss("colour_lat3");
        else begin
          e = qc3.pop_front();
          chk("colour_lat3", {red3, green3, blue3}, e.v);
          chk("colour_cycle_lat3", cyc, e.due);
        end
      end else chk("blank_lat3", {red3, green3, blue3}, 0);
      if (cyc >= rst_cyc + 5) begin
        chk("sync_delay3", {hs_out1, vs_out1, de_out1}, hist[(cyc - 3) & 7]);
        chk("sync_delay5", {hs_out3, vs_out3, de_out3}, hist[(cyc - 5) & 7]);
      end
      hist[cyc & 7] = {hs_in, vs_in, de_in};
      if (fs_out1) fs1++;
      if (fs_out3) fs3++;
    end
  end

  // One pixel clock of stimulus; pushes the model's expectation when de is high.
  task automatic drive(input int x, input int yd, input int ym, input bit de, input bit hs, input bit vs);
    bit src;
    int a, c;
    @(posedge clk); #1;
    draw_x = 10'(x); draw_y = 10'(yd); de_in = de; hs_in = hs; vs_in = vs;
    if (de) begin
      src = m_ok && (x / 2 < 320) && (ym / 2 < 240);
      a   = src ? (ym / 2) * 320 + x / 2 : m_last;
      if (src) m_last = a;
      c   = src ? (tp_sel ? bar(x) : (a & 12'hFFF)) : 0;
      qa.push_back('{cyc + 1, a});
      qc1.push_back('{cyc + 3, c});
      qc3.push_back('{cyc + 5, c});
    end
    if (!vs && m_vs_prev) m_ok = 1;
    m_vs_prev = vs;
  endtask

  task automatic line(input int yd, input int ym, input int nx);
    for (int i = 0; i < nx; i++) drive(XS[i], yd, ym, 1'b1, 1'b1, 1'b1);
    drive(0, yd, ym, 1'b0, 1'b1, 1'b1);
    drive(0, yd, ym, 1'b0, 1'b0, 1'b1);
    drive(0, yd, ym, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic vs_pulse();
    repeat (3) drive(0, 0, 0, 1'b0, 1'b1, 1'b0);
    drive(0, 0, 0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_rd_addr1"}, rd_addr1, 0);
    chk({tag, "_rd_addr3"}, rd_addr3, 0);
    chk({tag, "_rgb1"}, {red1, green1, blue1}, 0);
    chk({tag, "_rgb3"}, {red3, green3, blue3}, 0);
    chk({tag, "_sync1"}, {hs_out1, vs_out1, de_out1, fs_out1}, 4'b1100);
    chk({tag, "_sync3"}, {hs_out3, vs_out3, de_out3, fs_out3}, 4'b1100);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_vals("por");
    @(posedge clk); #5 rst_n = 1'b1; rst_cyc = cyc;

    // Frame 1: every line, plus two lines beyond the source height.
    fs_base1 = fs1; fs_base3 = fs3;
    vs_pulse();
    chk("frame_start_once1", fs1 - fs_base1, 1);
    chk("frame_start_once3", fs3 - fs_base3, 1);
    for (int y = 0; y < 482; y++) line(y, y, (y == 10) ? 1 : 6);

    // Frame reset coinciding with a de falling edge.
    fs_base1 = fs1; fs_base3 = fs3;
    drive(0, 482, 482, 1'b1, 1'b1, 1'b1);
    drive(0, 482, 482, 1'b0, 1'b1, 1'b0);
    drive(0, 482, 482, 1'b0, 1'b1, 1'b0);
    drive(0, 482, 482, 1'b0, 1'b1, 1'b1);
    for (int y = 0; y < 100; y++) line(y, y, (y < 3) ? 4 : 1);
    chk("frame_start_coincide1", fs1 - fs_base1, 1);
    chk("frame_start_coincide3", fs3 - fs_base3, 1);

    // vs asserted in the middle of line 100.
    fs_base1 = fs1; fs_base3 = fs3;
    drive(0, 100, 100, 1'b1, 1'b1, 1'b1);
    drive(2, 100, 100, 1'b1, 1'b1, 1'b0);
    drive(0, 100, 0, 1'b1, 1'b1, 1'b0);
    drive(4, 100, 0, 1'b1, 1'b1, 1'b1);
    drive(0, 100, 0, 1'b0, 1'b0, 1'b1);
    drive(0, 100, 0, 1'b0, 1'b1, 1'b1);
    line(101, 1, 4);
    line(102, 2, 4);
    chk("frame_start_midline1", fs1 - fs_base1, 1);
    chk("frame_start_midline3", fs3 - fs_base3, 1);

    // Blanking with the RAM forced to all ones.
    repeat (8) drive(0, 103, 3, 1'b0, 1'b1, 1'b1);
    force_fff = 1'b1;
    repeat (8) drive(0, 103, 3, 1'b0, 1'b0, 1'b1);
    force_fff = 1'b0;
    repeat (8) drive(0, 103, 3, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset in the middle of an active line.
    drive(0, 103, 3, 1'b1, 1'b1, 1'b1);
    drive(2, 103, 3, 1'b1, 1'b1, 1'b1);
    #4 rst_n = 1'b0;
    #1 reset_vals("midline_rst");
    qa.delete(); qc1.delete(); qc3.delete();
    m_ok = 0; m_last = 0; m_vs_prev = 1;
    de_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
    repeat (2) @(posedge clk);
    #5 rst_n = 1'b1; rst_cyc = cyc;
    line(0, 0, 4);
    vs_pulse();
    for (int y = 0; y < 3; y++) line(y, y, 4);

`ifdef FBR_TEST_PATTERN_EN
    vs_pulse();
    tp_sel = 1'b1;
    drive(0, 0, 0, 1'b1, 1'b1, 1'b1);
    drive(128, 0, 0, 1'b1, 1'b1, 1'b1);
    drive(896, 0, 0, 1'b0, 1'b1, 1'b1);
    repeat (3) drive(896, 0, 0, 1'b0, 1'b1, 1'b1);
    tp_sel = 1'b0;
`endif

    repeat (10) drive(0, 0, 0, 1'b0, 1'b1, 1'b1);
    chk("addr_queue_drained", qa.size(), 0);
    chk("colour_queue_drained_lat1", qc1.size(), 0);
    chk("colour_queue_drained_lat3", qc3.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
